// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_chan block.
// UART_PARITY_EN selects an 8E1 frame instead of 8N1.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_AW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_st_e;

  function automatic logic even_par(
    input logic [DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// 8x32 synchronous FIFO with registered read data.
// Status flags come from a registered occupancy count.
module uart_fifo
  import uart_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ren,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full,
  output logic [FIFO_AW-1:0] o_usedw
);

  localparam logic [FIFO_AW:0] LP_FULL =
    {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_wr;
  logic               w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LP_FULL);
  assign o_usedw = r_count[FIFO_AW-1:0];
  assign o_rdata = r_rdata;

  assign w_wr = i_wen & ~o_full;
  assign w_rd = i_ren & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 5'd1;
      if (w_rd) begin
        r_rptr  <= r_rptr + 5'd1;
        r_rdata <= r_mem[r_rptr];
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_chan.sv
// Full-duplex UART channel: TX/RX FIFOs, serializer, deserializer.
// Define UART_PARITY_EN for an 8E1 frame with RX parity checking.
module uart_chan
  import uart_pkg::*;
#(
  parameter logic [15:0] BAUD_RST    = 16'd433,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_latch_baud,
  input  logic [15:0] i_baud_word,
  input  logic        i_self_loop,
  input  logic        i_tx_fifo_wen,
  input  logic [7:0]  i_tx_fifo_wdata,
  output logic        o_tx_fifo_empty,
  output logic        o_tx_fifo_full,
  output logic [4:0]  o_tx_fifo_usedw,
  input  logic        i_rx_fifo_ren,
  output logic [7:0]  o_rx_fifo_rdata,
  output logic        o_rx_fifo_empty,
  output logic        o_rx_fifo_full,
  output logic [4:0]  o_rx_fifo_usedw,
  output logic        o_tx_work,
  output logic        o_rx_overflow,
  output logic        o_rx_frame_err,
  output logic        o_rx_parity_err,
  output logic        o_uart_txd,
  input  logic        i_uart_rxd
);

  logic [15:0] r_baud_pend;

  uart_st_e    r_tx_st, w_tx_st;
  logic [15:0] r_tx_div, r_tx_cnt, w_tx_cnt;
  logic [2:0]  r_tx_bit, w_tx_bit;
  logic        r_txd, w_txd;
  logic        w_tx_ren, w_tx_end;
  logic [7:0]  w_tx_rdata;

  uart_st_e    r_rx_st, w_rx_st;
  logic [15:0] r_rx_div, r_rx_cnt, w_rx_cnt;
  logic [15:0] w_rx_half;
  logic [2:0]  r_rx_bit, w_rx_bit;
  logic [7:0]  r_rx_sh, w_rx_sh;
  logic [SYNC_STAGES-1:0] r_sync;
  logic        r_loop;
  logic        w_rxd_s, w_rx_end;
  logic        w_rx_wen, w_rx_full;
  logic        w_ovf, w_ferr;
  logic        r_ovf, r_ferr;
`ifdef UART_PARITY_EN
  logic        r_par_bad, w_par_bad;
  logic        w_perr, r_perr;
`endif

  uart_fifo u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wen   (i_tx_fifo_wen),
    .i_wdata (i_tx_fifo_wdata),
    .i_ren   (w_tx_ren),
    .o_rdata (w_tx_rdata),
    .o_empty (o_tx_fifo_empty),
    .o_full  (o_tx_fifo_full),
    .o_usedw (o_tx_fifo_usedw)
  );

  uart_fifo u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wen   (w_rx_wen),
    .i_wdata (r_rx_sh),
    .i_ren   (i_rx_fifo_ren),
    .o_rdata (o_rx_fifo_rdata),
    .o_empty (o_rx_fifo_empty),
    .o_full  (w_rx_full),
    .o_usedw (o_rx_fifo_usedw)
  );

  assign o_rx_fifo_full = w_rx_full;
  assign o_uart_txd     = r_txd;
  assign o_tx_work      = (r_tx_st != ST_IDLE);
  assign o_rx_overflow  = r_ovf;
  assign o_rx_frame_err = r_ferr;
`ifdef UART_PARITY_EN
  assign o_rx_parity_err = r_perr;
`else
  assign o_rx_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_baud_pend <= BAUD_RST;
    else if (i_latch_baud) r_baud_pend <= i_baud_word;
  end

  // TX: the popped byte stays in the FIFO read register for the whole frame
  assign w_tx_end = (r_tx_cnt == r_tx_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_st  <= ST_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_txd    <= 1'b1;
      r_tx_div <= BAUD_RST;
    end else begin
      r_tx_st  <= w_tx_st;
      r_tx_cnt <= w_tx_cnt;
      r_tx_bit <= w_tx_bit;
      r_txd    <= w_txd;
      if (r_tx_st == ST_IDLE) r_tx_div <= r_baud_pend;
    end
  end

  always_comb begin
    w_tx_st  = r_tx_st;
    w_tx_cnt = r_tx_cnt + 16'd1;
    w_tx_bit = r_tx_bit;
    w_txd    = r_txd;
    w_tx_ren = 1'b0;
    unique case (r_tx_st)
      ST_IDLE: begin
        w_tx_cnt = '0;
        w_txd    = 1'b1;
        if (!o_tx_fifo_empty) begin
          w_tx_ren = 1'b1;
          w_tx_st  = ST_START;
          w_txd    = 1'b0;
        end
      end
      ST_START: begin
        if (w_tx_end) begin
          w_tx_st  = ST_DATA;
          w_tx_cnt = '0;
          w_tx_bit = '0;
          w_txd    = w_tx_rdata[0];
        end
      end
      ST_DATA: begin
        if (w_tx_end) begin
          w_tx_cnt = '0;
          w_tx_bit = r_tx_bit + 3'd1;
          w_txd    = w_tx_rdata[w_tx_bit];
          if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_st = ST_PARITY;
            w_txd   = even_par(w_tx_rdata);
`else
            w_tx_st = ST_STOP;
            w_txd   = 1'b1;
`endif
          end
        end
      end
      ST_PARITY: begin
        if (w_tx_end) begin
          w_tx_cnt = '0;
          w_tx_st  = ST_STOP;
          w_txd    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tx_end) begin
          w_tx_cnt = '0;
          if (!o_tx_fifo_empty) begin
            w_tx_ren = 1'b1;
            w_tx_st  = ST_START;
            w_txd    = 1'b0;
          end else begin
            w_tx_st = ST_IDLE;
          end
        end
      end
      default: begin
        w_tx_st = ST_IDLE;
        w_txd   = 1'b1;
      end
    endcase
  end

  // Loopback bypasses the synchronizer: the TX line is already in clk domain
  assign w_rxd_s   = r_loop ? r_txd : r_sync[SYNC_STAGES-1];
  assign w_rx_end  = (r_rx_cnt == r_rx_div);
  assign w_rx_half = {1'b0, r_rx_div[15:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '1;
      r_loop   <= 1'b0;
      r_rx_st  <= ST_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_div <= BAUD_RST;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_uart_rxd};
      r_rx_st  <= w_rx_st;
      r_rx_cnt <= w_rx_cnt;
      r_rx_bit <= w_rx_bit;
      r_rx_sh  <= w_rx_sh;
      r_ovf    <= w_ovf;
      r_ferr   <= w_ferr;
      if (r_rx_st == ST_IDLE) begin
        r_rx_div <= r_baud_pend;
        r_loop   <= i_self_loop;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad;
      r_perr    <= w_perr;
    end
  end
`endif

  always_comb begin
    w_rx_st  = r_rx_st;
    w_rx_cnt = r_rx_cnt + 16'd1;
    w_rx_bit = r_rx_bit;
    w_rx_sh  = r_rx_sh;
    w_rx_wen = 1'b0;
    w_ovf    = 1'b0;
    w_ferr   = 1'b0;
`ifdef UART_PARITY_EN
    w_par_bad = r_par_bad;
    w_perr    = 1'b0;
`endif
    unique case (r_rx_st)
      ST_IDLE: begin
        w_rx_cnt = '0;
        if (!w_rxd_s) w_rx_st = ST_START;
      end
      ST_START: begin
        if (r_rx_cnt == w_rx_half) begin
          w_rx_cnt = '0;
          w_rx_bit = '0;
          w_rx_st  = w_rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt = '0;
          w_rx_sh  = {w_rxd_s, r_rx_sh[7:1]};
          w_rx_bit = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_rx_st = ST_PARITY;
`else
            w_rx_st = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_rx_end) begin
          w_rx_cnt  = '0;
          w_par_bad = (w_rxd_s != even_par(r_rx_sh));
          w_rx_st   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid stop bit so a following start edge is not missed
        if (w_rx_end) begin
          w_rx_cnt = '0;
          w_rx_st  = ST_IDLE;
          if (!w_rxd_s) w_ferr = 1'b1;
`ifdef UART_PARITY_EN
          else if (r_par_bad) w_perr = 1'b1;
`endif
          else if (w_rx_full) w_ovf = 1'b1;
          else w_rx_wen = 1'b1;
        end
      end
      default: w_rx_st = ST_IDLE;
    endcase
  end

endmodule

// File: doc/uart_chan.md
Name: uart_chan

Overview:
- One full-duplex UART channel: 32-entry TX FIFO, serializer, deserializer, 32-entry RX FIFO and a run-time baud divisor.
- Sits directly downstream of the acquisition work controller. Two instances are used, one per channel 0/1.
- Consumes the controller's baud/loop/FIFO-write/FIFO-read signals; returns FIFO status, tx_work and rx_overflow.

Parameters:
- BAUD_RST, 16'd433, baud_word value loaded at reset (50 MHz, 115200 Bd).
- SYNC_STAGES, 2, number of rxd synchronizer flops (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- latch_baud  in  1  one-cycle pulse; capture baud_word
- baud_word  in  16  bit period minus 1, in clk cycles; legal >=3
- self_loop  in  1  1 = RX path fed from internal TX line
- tx_fifo_wen  in  1  write tx_fifo_wdata to TX FIFO
- tx_fifo_wdata  in  8  byte to transmit
- tx_fifo_empty  out  1  TX FIFO empty
- tx_fifo_full  out  1  TX FIFO full
- tx_fifo_usedw  out  5  TX occupancy mod 32
- rx_fifo_ren  in  1  read request
- rx_fifo_rdata  out  8  received byte
- rx_fifo_empty  out  1  RX FIFO empty
- rx_fifo_full  out  1  RX FIFO full
- rx_fifo_usedw  out  5  RX occupancy mod 32
- tx_work  out  1  transmitter busy
- rx_overflow  out  1  one-cycle pulse: byte dropped, RX FIFO full
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- rx_parity_err  out  1  one-cycle pulse: parity mismatch
- uart_txd  out  1  serial out, idle high
- uart_rxd  in  1  serial in, asynchronous

Behaviour:
- Global: all state changes on rising clk edges.
- Reset:
  - FIFOs empty; empty=1, full=0, usedw=0; rx_fifo_rdata=0.
  - uart_txd=1; tx_work=0; all error pulses 0.
  - Baud register = BAUD_RST; synchronizer flops = 1.
- Frame format: 8N1, LSB first; bit period = baud_reg+1 clk cycles.
- Baud register:
  - latch_baud captures baud_word into a pending register.
  - TX and RX each copy it into their active divisor only when IDLE.
  - A frame in flight finishes with the old divisor.
- FIFOs:
  - Write while full is ignored; read while empty is ignored and rdata holds.
  - rx_fifo_rdata is valid 1 cycle after an accepted ren (registered).
  - usedw counts mod 32, so usedw=0 with full=1 at 32 entries.
  - Simultaneous read and write on a non-empty, non-full FIFO leaves usedw unchanged.
  - Flags and usedw update the cycle after the accepted access.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START when the FIFO is non-empty; pop the head byte. txd goes low 1 cycle after the pop.
  - START lasts 1 bit period.
  - DATA lasts 8 bit periods.
  - STOP holds txd=1 for 1 bit period, then -> START if the FIFO is non-empty (back-to-back frames), else IDLE.
  - tx_work=1 in every state except IDLE.
- RX path:
  - rxd_s = synchronized uart_rxd; when self_loop=1, rxd_s = uart_txd register instead (no synchronizer). uart_txd keeps driving in loop mode.
  - self_loop changes take effect only when RX is IDLE.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on rxd_s=0.
  - START: at half period (baud_reg>>1), rxd_s=1 -> IDLE (glitch rejected); else -> DATA.
  - DATA: 8 samples, one per full period from mid-start.
  - STOP: sample at mid-bit.
    - Stop=0: pulse rx_frame_err and discard the byte.
    - Stop=1 and FIFO full: pulse rx_overflow and discard the byte.
    - Otherwise write the byte to the RX FIFO.
  - Return to IDLE right after the stop sample (half-bit early), so back-to-back frames are caught.
  - rx_parity_err stays 0 unless UART_PARITY_EN is defined.
- Mid-operation reset: FSMs go to IDLE immediately; a partial byte is lost; txd=1 next cycle.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame becomes 8E1; TX inserts an even-parity bit after D7.
  - RX samples a parity bit; on mismatch it pulses rx_parity_err and discards the byte.
  - A frame error takes precedence: only rx_frame_err is pulsed.
- Not defined:
  - 8N1 frame; rx_parity_err is tied 0.

Decomposition:
- Package uart_pkg:
  - State encodings for TX and RX (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - DATA_W=8, FIFO_DEPTH=32, FIFO_AW=5.
- Sub-module uart_fifo:
  - Sync FIFO, 8x32, registered read, full/empty/usedw.
  - Instantiated twice (TX, RX).

Test Plan:
- Serial waveform:
  - baud_word=3 via latch_baud, write 0xA5.
  - txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clk; tx_work high 40 clk.
- Self loop:
  - self_loop=1, write 0x3C then 0xC3.
  - RX FIFO gets 0x3C, 0xC3; rdata=0x3C 1 cycle after the first ren; usedw 2->1->0.
- RX overflow:
  - 33 frames on uart_rxd, no reads.
  - full=1, usedw=0; exactly one rx_overflow pulse on the 33rd stop sample; first 32 bytes read intact.
- Glitch and frame error:
  - rxd low 1 clk at baud_word=15 -> no byte, no error.
  - Frame 0x55 with stop bit low -> rx_frame_err pulse, FIFO unchanged.
- Baud change and TX full:
  - Change baud_word 3->7 mid-frame: current frame stays 4 clk/bit, next frame 8 clk/bit.
  - A 33rd write while full is ignored and usedw stays 0.
- UART_PARITY_EN:
  - 0x07 sent with parity bit 1; rx with a flipped parity bit -> rx_parity_err pulse, no FIFO write.
